// File: rtl/riscv_core_pkg.sv
// Shared definitions for the riscv_core slice: default parameters, opcode and funct3
// encodings, the control FSM state type and the ALU operation type.
package riscv_core_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam int          DMEM_WORDS_DEFAULT = 256;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
  localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_LB   = 3'd0, F3_LH  = 3'd1, F3_LW  = 3'd2, F3_LBU  = 3'd4;
  localparam logic [2:0] F3_LHU  = 3'd5;
  localparam logic [2:0] F3_SB   = 3'd0, F3_SH  = 3'd1, F3_SW  = 3'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EXEC} state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // Only register-register ops may subtract; bit 30 selects SRA for both forms.
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic f7b5,
                                         input logic is_reg);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      F3_ADD:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = f7b5 ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_core_if.sv
// Instruction fetch port: the core requests by address, the source answers with valid + word.
interface riscv_core_if;
  logic        exIns_valid;
  logic [31:0] exIns_in;
  logic        exIns_ren;
  logic [31:0] exIns_addr;

  modport master (output exIns_ren, exIns_addr, input exIns_valid, exIns_in);
  modport slave  (input exIns_ren, exIns_addr, output exIns_valid, exIns_in);
endinterface

// File: rtl/riscv_core_regfile.sv
// 32x32 integer register file: two asynchronous read ports, one synchronous write port,
// x0 reads as zero and is never written, whole array cleared while nrst is high.
module riscv_core_regfile
  import riscv_core_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  input  logic        we_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk) begin
    if (nrst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && (rd_addr_i != 5'd0)) begin
      regs_q[rd_addr_i] <= rd_data_i;
    end
  end

  assign rs1_data_o = (rs1_addr_i == 5'd0) ? '0 : regs_q[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == 5'd0) ? '0 : regs_q[rs2_addr_i];

endmodule

// File: rtl/riscv_core.sv
// Multi-cycle RV32I core (IDLE -> FETCH -> EXEC) with internal register file and data memory.
// Define CORE_TRACE_EN to expose debug outputs pc and inst.
module riscv_core
  import riscv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          DMEM_WORDS = DMEM_WORDS_DEFAULT
) (
  input  logic          clk,
  input  logic          nrst,
  riscv_core_if.master  exIns
`ifdef CORE_TRACE_EN
  ,
  output logic [31:0]   pc,
  output logic [31:0]   inst
`endif
);

  localparam int AW = $clog2(DMEM_WORDS);

  state_e      state_q;
  logic [31:0] pc_q, ir_q;
  logic        ren_q;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_data, rs2_data, op_b, alu_res, pc_d, rd_wdata;
  logic [31:0] mem_addr, ld_word, ld_data, st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [3:0]  st_be;
  logic        rd_we, st_en, br_taken;
  alu_op_e     alu_op;
  logic [31:0] dmem_q [DMEM_WORDS];
  logic        unused_addr_bits;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u  = {ir_q[31:12], 12'b0};
  assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  riscv_core_regfile u_regfile (
    .clk        (clk),
    .nrst       (nrst),
    .rs1_addr_i (rs1),
    .rs2_addr_i (rs2),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .we_i       (rd_we && (state_q == ST_EXEC)),
    .rd_addr_i  (rd),
    .rd_data_i  (rd_wdata)
  );

  assign op_b   = (opcode == OPC_OP) ? rs2_data : imm_i;
  assign alu_op = alu_decode(f3, ir_q[30], opcode == OPC_OP);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = rs1_data + op_b;
      ALU_SUB:  alu_res = rs1_data - op_b;
      ALU_SLL:  alu_res = rs1_data << op_b[4:0];
      ALU_SLT:  alu_res = {31'b0, $signed(rs1_data) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'b0, rs1_data < op_b};
      ALU_XOR:  alu_res = rs1_data ^ op_b;
      ALU_SRL:  alu_res = rs1_data >> op_b[4:0];
      ALU_SRA:  alu_res = $unsigned($signed(rs1_data) >>> op_b[4:0]);
      ALU_OR:   alu_res = rs1_data | op_b;
      ALU_AND:  alu_res = rs1_data & op_b;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (f3)
      F3_BEQ:  br_taken = (rs1_data == rs2_data);
      F3_BNE:  br_taken = (rs1_data != rs2_data);
      F3_BLT:  br_taken = ($signed(rs1_data) < $signed(rs2_data));
      F3_BGE:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: br_taken = (rs1_data < rs2_data);
      F3_BGEU: br_taken = (rs1_data >= rs2_data);
      default: br_taken = 1'b0;
    endcase
  end

  // Data memory: word index from the low address bits, lanes from addr[1:0].
  assign mem_addr         = rs1_data + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign unused_addr_bits = ^mem_addr[31:AW+2];
  assign ld_word          = dmem_q[mem_addr[AW+1:2]];
  assign ld_byte          = ld_word[{mem_addr[1:0], 3'b000} +: 8];
  assign ld_half          = mem_addr[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    ld_data = ld_word;
    case (f3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  ld_data = {24'b0, ld_byte};
      F3_LHU:  ld_data = {16'b0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

  always_comb begin
    st_wdata = rs2_data;
    st_be    = 4'b1111;
    case (f3)
      F3_SB: begin
        st_wdata = {4{rs2_data[7:0]}};
        st_be    = 4'b0001 << mem_addr[1:0];
      end
      F3_SH: begin
        st_wdata = {2{rs2_data[15:0]}};
        st_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = rs2_data;
        st_be    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    pc_d     = pc_q + 32'd4;
    rd_we    = 1'b0;
    rd_wdata = alu_res;
    st_en    = 1'b0;
    case (opcode)
      OPC_LUI:    begin rd_we = 1'b1; rd_wdata = imm_u; end
      OPC_AUIPC:  begin rd_we = 1'b1; rd_wdata = pc_q + imm_u; end
      OPC_JAL:    begin rd_we = 1'b1; rd_wdata = pc_q + 32'd4; pc_d = pc_q + imm_j; end
      OPC_JALR:   begin
        rd_we    = 1'b1;
        rd_wdata = pc_q + 32'd4;
        pc_d     = (rs1_data + imm_i) & ~32'd1;
      end
      OPC_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
      OPC_LOAD:   begin rd_we = 1'b1; rd_wdata = ld_data; end
      OPC_STORE:  st_en = 1'b1;
      OPC_OPIMM,
      OPC_OP:     rd_we = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      for (int i = 0; i < DMEM_WORDS; i++) dmem_q[i] <= '0;
    end else if (st_en && (state_q == ST_EXEC)) begin
      for (int b = 0; b < 4; b++)
        if (st_be[b]) dmem_q[mem_addr[AW+1:2]][8*b +: 8] <= st_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ren_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_FETCH;
          ren_q   <= 1'b1;
        end
        ST_FETCH: if (exIns.exIns_valid) begin
          ir_q    <= exIns.exIns_in;
          state_q <= ST_EXEC;
          ren_q   <= 1'b0;
        end
        ST_EXEC: begin
          pc_q    <= pc_d;
          state_q <= ST_FETCH;
          ren_q   <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ren_q   <= 1'b0;
        end
      endcase
    end
  end

  assign exIns.exIns_ren  = ren_q;
  assign exIns.exIns_addr = pc_q;

`ifdef CORE_TRACE_EN
  assign pc   = pc_q;
  assign inst = ir_q;
`endif

endmodule

// File: tb/tb_riscv_core.sv
// Scoreboard bench for riscv_core: expected fetch addresses and register results are queued
// as each instruction is issued and compared when the core requests / retires it.
module tb_riscv_core;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  riscv_core_if bus ();

`ifdef CORE_TRACE_EN
  logic [31:0] tr_pc, tr_inst;
  riscv_core dut (.clk(clk), .nrst(nrst), .exIns(bus), .pc(tr_pc), .inst(tr_inst));
`else
  riscv_core dut (.clk(clk), .nrst(nrst), .exIns(bus));
`endif

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } reg_exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_addr_q[$];
  reg_exp_t    exp_reg_q[$];
  logic [31:0] model_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    return dut.u_regfile.regs_q[idx];
  endfunction

  task automatic wait_fetch(input string tag, output int waited);
    waited = 0;
    while (bus.exIns_ren !== 1'b1 && waited < 20) begin
      @(posedge clk);
      @(negedge clk);
      waited++;
    end
    chk({tag, "_ren"}, {31'b0, bus.exIns_ren}, 32'd1);
  endtask

  task automatic issue(input int k, input logic [31:0] instr, input int stall, input bit has_rd);
    int          waited;
    logic [31:0] a0, exp_addr;
    reg_exp_t    re;
    wait_fetch($sformatf("fetch%0d", k), waited);
    chk($sformatf("thru%0d", k), waited, 0);
    a0 = bus.exIns_addr;
    for (int s = 0; s < stall; s++) begin
      bus.exIns_valid = 1'b0;
      bus.exIns_in    = $urandom;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("stall_ren%0d_%0d", k, s), {31'b0, bus.exIns_ren}, 32'd1);
      chk($sformatf("stall_addr%0d_%0d", k, s), bus.exIns_addr, a0);
    end
    exp_addr = exp_addr_q.pop_front();
    chk($sformatf("fetch_addr%0d", k), bus.exIns_addr, exp_addr);
    bus.exIns_valid = 1'b1;
    bus.exIns_in    = instr;
    @(posedge clk);
    @(negedge clk);
    // EXEC cycle: valid with a junk word must be ignored.
    bus.exIns_in = 32'h0010_0093;
    @(posedge clk);
    @(negedge clk);
    bus.exIns_valid = 1'b0;
    bus.exIns_in    = '0;
    if (has_rd) begin
      re = exp_reg_q.pop_front();
      chk($sformatf("x%0d_after%0d", re.rd, k), rf_read(re.rd), re.val);
    end
    $display("[TB] insn %0d pc=%h instr=%h stall=%0d", k, exp_addr, instr, stall);
  endtask

  int k_idx = 0;

  task automatic step(input logic [31:0] instr, input int stall, input bit has_rd,
                      input logic [4:0] rd, input logic [31:0] val, input logic [31:0] npc);
    exp_addr_q.push_back(model_pc);
    if (has_rd) exp_reg_q.push_back('{rd: rd, val: val});
    model_pc = npc;
    issue(k_idx, instr, stall, has_rd);
    k_idx++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    nrst            = 1'b1;
    bus.exIns_valid = 1'b0;
    bus.exIns_in    = '0;
    model_pc        = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ren", {31'b0, bus.exIns_ren}, 32'd0);
    chk("rst_addr", bus.exIns_addr, 32'h0);
    nrst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_ren", {31'b0, bus.exIns_ren}, 32'd1);
    chk("post_rst_addr", bus.exIns_addr, 32'h0);

    //    instr         stall rd?  rd  value          next pc
    step(32'h00500093, 0, 1, 1,  32'd5,          32'h04); // ADDI x1,x0,5
    step(32'h00108133, 0, 1, 2,  32'd10,         32'h08); // ADD x2,x1,x1
    step(32'h00208463, 0, 0, 0,  32'd0,          32'h0C); // BEQ not taken
    step(32'h00A00093, 3, 1, 1,  32'd10,         32'h10); // ADDI x1,x0,10 after stall
    step(32'h00208463, 0, 0, 0,  32'd0,          32'h18); // BEQ taken
    step(32'h010000ef, 0, 1, 1,  32'h1C,         32'h28); // JAL x1,+16
    step(32'h00202023, 0, 0, 0,  32'd0,          32'h2C); // SW x2,0(x0)
    step(32'h00002183, 0, 1, 3,  32'd10,         32'h30); // LW x3,0(x0)
    step(32'h08000293, 0, 1, 5,  32'h80,         32'h34); // ADDI x5,x0,0x80
    step(32'h00500223, 1, 0, 0,  32'd0,          32'h38); // SB x5,4(x0)
    step(32'h00400303, 0, 1, 6,  32'hFFFFFF80,   32'h3C); // LB x6,4(x0)
    step(32'h00404383, 0, 1, 7,  32'h80,         32'h40); // LBU x7,4(x0)
    step(32'h00402703, 0, 1, 14, 32'h80,         32'h44); // LW x14,4(x0)
    step(32'h00700013, 0, 1, 0,  32'd0,          32'h48); // ADDI x0,x0,7
    step(32'hFFD00213, 0, 1, 4,  32'hFFFFFFFD,   32'h4C); // ADDI x4,x0,-3
    step(32'h40125493, 0, 1, 9,  32'hFFFFFFFE,   32'h50); // SRAI x9,x4,1
    step(32'h00403533, 0, 1, 10, 32'd1,          32'h54); // SLTU x10,x0,x4
    step(32'h004025B3, 0, 1, 11, 32'd0,          32'h58); // SLT x11,x0,x4
    step(32'h123456B7, 0, 1, 13, 32'h12345000,   32'h5C); // LUI x13
    step(32'h00000073, 0, 0, 0,  32'd0,          32'h60); // ECALL as NOP
    step(32'h061007E7, 0, 1, 15, 32'h64,         32'h60); // JALR x15,0x61(x0)

    wait_fetch("final", waited);
    chk("final_addr", bus.exIns_addr, model_pc);

    // Reset while fetching: back to IDLE with cleared state.
    nrst            = 1'b1;
    bus.exIns_valid = 1'b1;
    bus.exIns_in    = 32'h00500093;
    @(posedge clk);
    @(negedge clk);
    bus.exIns_valid = 1'b0;
    chk("mid_rst_ren", {31'b0, bus.exIns_ren}, 32'd0);
    chk("mid_rst_addr", bus.exIns_addr, 32'h0);
    chk("mid_rst_x2", rf_read(5'd2), 32'd0);
    chk("mid_rst_dmem", dut.dmem_q[0], 32'd0);
    nrst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("restart_ren", {31'b0, bus.exIns_ren}, 32'd1);
    chk("restart_addr", bus.exIns_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
